// File: rtl/cube_iter.sv
// Iterative unsigned fixed-point cuber: number_out = number_in^3 via two serial shift-add multiplies.
// Optional `CUBE_ROUND_EN selects round-to-nearest at each stage instead of truncation.
module cube_iter #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] number_in,
    output logic [WIDTH-1:0] number_out,
    output logic             done,
    output logic             busy,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, FIN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic               ovf1;

    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] acc_rnd;
    logic [WIDTH-1:0]   stage_res;
    logic               stage_ovf;
    logic               last;

    // acc_sum already includes this cycle's partial product, so the final step can extract directly.
    always_comb begin
        acc_sum = acc + (mplier[0] ? mcand : '0);
`ifdef CUBE_ROUND_EN
        acc_rnd = acc_sum + ({{(2*WIDTH-1){1'b0}}, 1'b1} << (FRAC - 1));
`else
        acc_rnd = acc_sum;
`endif
        stage_res = acc_rnd[WIDTH+FRAC-1:FRAC];
        stage_ovf = |acc_rnd[2*WIDTH-1:WIDTH+FRAC];
        last      = (cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            x_reg      <= '0;
            mplier     <= '0;
            mcand      <= '0;
            acc        <= '0;
            ovf1       <= 1'b0;
            number_out <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_reg  <= number_in;
                        mplier <= number_in;
                        mcand  <= {{WIDTH{1'b0}}, number_in};
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= MUL1;
                    end
                end
                MUL1: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        ovf1   <= stage_ovf;
                        mcand  <= {{WIDTH{1'b0}}, stage_res};
                        mplier <= x_reg;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= MUL2;
                    end
                end
                MUL2: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        overflow   <= ovf1 | stage_ovf;
                        number_out <= (ovf1 | stage_ovf) ? {WIDTH{1'b1}} : stage_res;
                        done       <= 1'b1;
                        state      <= FIN;
                    end
                end
                FIN: begin
                    // A start seen here is dropped; the requester must re-assert in IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cube_iter.sv
// Directed bench for cube_iter: vector table, latency/handshake sequences, reset abort, round trip.
module tb_cube_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] number_in;
    logic [31:0] number_out;
    logic        done;
    logic        busy;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    cube_iter #(.WIDTH(32), .FRAC(16)) dut (
        .clk(clk), .reset(reset), .start(start), .number_in(number_in),
        .number_out(number_out), .done(done), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts an operation and waits for done; lat counts negedges after the accepting edge.
    task automatic run_op(input logic [31:0] val, output logic [31:0] res,
                          output logic ovf, output int lat);
        @(negedge clk);
        start     = 1'b1;
        number_in = val;
        @(posedge clk);
        #1;
        start     = 1'b0;
        number_in = $urandom;
        lat = 0;
        res = '0;
        ovf = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("busy_after_start", 32'(busy), 32'd1);
            if (done) begin
                res = number_out;
                ovf = overflow;
                break;
            end
        end
        if (lat >= 200) chk("done_timeout", 32'(lat), 32'd65);
    endtask

    logic [31:0] res;
    logic        ovf;
    int          lat;
    int          ndone;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        number_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_number_out", number_out, 32'h0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);

        // Values chosen to be exact, so they hold with or without rounding.
        vecs.push_back('{32'h0002_0000, 32'h0008_0000, 1'b0});
        vecs.push_back('{32'h0003_0000, 32'h001B_0000, 1'b0});
        vecs.push_back('{32'h000A_0000, 32'h03E8_0000, 1'b0});
        vecs.push_back('{32'h0000_C000, 32'h0000_6C00, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{32'h0001_8000, 32'h0003_6000, 1'b0});
        vecs.push_back('{32'h0028_0000, 32'hFA00_0000, 1'b0});
        vecs.push_back('{32'h0029_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'h0100_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{32'h0001_0000, 32'h0001_0000, 1'b0});

        foreach (vecs[i]) begin
            run_op(vecs[i].din, res, ovf, lat);
            chk($sformatf("vec%0d_out", i), res, vecs[i].dout);
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd65);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d_busy_low", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_out_held", i), number_out, vecs[i].dout);
        end

        // Back-to-back: start held high right after done is accepted two cycles later.
        @(negedge clk);
        start = 1'b1;
        number_in = 32'h0002_0000;
        @(posedge clk);
        #1 number_in = 32'h0003_0000;
        lat = 0;
        ndone = 0;
        while (ndone < 2 && lat < 300) begin
            @(negedge clk);
            lat++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("b2b_first_lat", 32'(lat), 32'd65);
                    chk("b2b_first_out", number_out, 32'h0008_0000);
                end else begin
                    chk("b2b_second_lat", 32'(lat), 32'd131);
                    chk("b2b_second_out", number_out, 32'h001B_0000);
                end
            end
        end
        start = 1'b0;
        chk("b2b_two_dones", 32'(ndone), 32'd2);
        repeat (3) @(negedge clk);

        // start pulses while busy (+10) and in the done cycle (+65) are ignored.
        @(negedge clk);
        start = 1'b1;
        number_in = 32'h0004_0000;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        ndone = 0;
        while (lat < 160) begin
            @(negedge clk);
            lat++;
            if (done) begin
                ndone++;
                chk("ignore_lat", 32'(lat), 32'd65);
                chk("ignore_out", number_out, 32'h0040_0000);
            end
            if (lat == 66) chk("ignore_busy_low", 32'(busy), 32'd0);
            if (lat == 10 || lat == 65) begin
                start = 1'b1;
                number_in = 32'h0005_0000;
            end else begin
                start = 1'b0;
                number_in = $urandom;
            end
        end
        chk("ignore_single_done", 32'(ndone), 32'd1);
        chk("ignore_idle_busy", 32'(busy), 32'd0);

        // Reset mid-operation drops the result.
        @(negedge clk);
        start = 1'b1;
        number_in = 32'h0005_0000;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_number_out", number_out, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(32'h0005_0000, res, ovf, lat);
        chk("abort_fresh_out", res, 32'h007D_0000);
        chk("abort_fresh_lat", 32'(lat), 32'd65);

        // Round trip with cube roots of 8, 27, 64, 125, 1000.
        begin
            logic [31:0] roots[5];
            logic [15:0] orig[5];
            roots = '{32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h000A_0000};
            orig  = '{16'd8, 16'd27, 16'd64, 16'd125, 16'd1000};
            for (int i = 0; i < 5; i++) begin
                run_op(roots[i], res, ovf, lat);
                chk($sformatf("round_trip_%0d", orig[i]), 32'(res[31:16]), 32'(orig[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
